// File: rtl/prog_loader.sv
// Boot-time program loader: takes a framed byte stream (count header, words, XOR checksum),
// writes the words into SISC instruction memory and releases the core only after a good load.
module prog_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_f,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        im_we,
    output logic        core_rst_f,
    output logic        busy,
    output logic        err,
    output logic [15:0] words_loaded
);

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, CHK, RUN, ERR} state_t;

    state_t      state, state_nxt;
    logic [15:0] count;
    logic [1:0]  byte_idx;
    logic [23:0] word_acc;
    logic [7:0]  csum;
    logic        loading;
    logic        accept;
    logic        can_start;
    logic [15:0] hdr_count;

    assign loading    = (state == HDR_HI) || (state == HDR_LO) || (state == DATA) || (state == CHK);
    // The write cycle steals the handshake so the next byte is held by the source.
    assign in_ready   = loading && !im_we;
    assign accept     = in_valid && in_ready;
    assign busy       = loading;
    assign err        = (state == ERR);
    assign core_rst_f = (state == RUN);
    assign can_start  = start && ((state == IDLE) || (state == RUN) || (state == ERR));
    assign hdr_count  = {count[15:8], in_data};

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RUN, ERR: if (start) state_nxt = HDR_HI;
            HDR_HI: if (accept) state_nxt = HDR_LO;
            HDR_LO: begin
                if (accept) begin
                    if ({1'b0, hdr_count} > MAX_W) state_nxt = ERR;
                    else if (hdr_count == 16'd0)   state_nxt = CHK;
                    else                           state_nxt = DATA;
                end
            end
            DATA: if (im_we && (words_loaded + 16'd1 == count)) state_nxt = CHK;
            CHK: begin
                if (accept) state_nxt = (in_data == csum) ? RUN : ERR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            count        <= '0;
            byte_idx     <= '0;
            word_acc     <= '0;
            csum         <= '0;
            im_we        <= 1'b0;
            im_addr      <= '0;
            im_wdata     <= '0;
            words_loaded <= '0;
        end else begin
            im_we <= 1'b0;
            if (can_start) begin
                count        <= '0;
                byte_idx     <= '0;
                csum         <= '0;
                words_loaded <= '0;
            end
            // The checksum byte itself is compared, not folded in.
            if (accept && (state != CHK)) csum <= csum ^ in_data;
            if (accept && (state == HDR_HI)) count[15:8] <= in_data;
            if (accept && (state == HDR_LO)) count[7:0]  <= in_data;
            if (accept && (state == DATA)) begin
                if (byte_idx == 2'd3) begin
                    im_we    <= 1'b1;
                    im_wdata <= {word_acc, in_data};
                    im_addr  <= BASE_ADDR + words_loaded;
                    byte_idx <= '0;
                end else begin
                    word_acc <= {word_acc[15:0], in_data};
                    byte_idx <= byte_idx + 2'd1;
                end
            end
            if (im_we) words_loaded <= words_loaded + 16'd1;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a stream-level model predicts writes and the load outcome,
// a negedge monitor checks every write against it, and literal checks pin the test-plan results.
module tb_prog_loader;

    localparam logic [15:0] BASE = 16'h0000;
    localparam int          MAXW = 1024;

    logic        clk = 1'b0;
    logic        rst_f = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] im_addr;
    logic [31:0] im_wdata;
    logic        im_we;
    logic        core_rst_f;
    logic        busy;
    logic        err;
    logic [15:0] words_loaded;

    int checks = 0;
    int failures = 0;

    logic [7:0]  stream[$];
    logic [15:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [15:0] act_addr[$];
    logic [31:0] act_data[$];
    logic        exp_err;
    logic [15:0] exp_words;

    prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst_f(rst_f), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .im_addr(im_addr), .im_wdata(im_wdata), .im_we(im_we),
        .core_rst_f(core_rst_f), .busy(busy), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every write must match the head of the predicted write list, with the handshake closed.
    always @(negedge clk) begin
        if (rst_f && im_we) begin
            act_addr.push_back(im_addr);
            act_data.push_back(im_wdata);
            chk("in_ready_in_write", {31'b0, in_ready}, 32'd0);
            if (exp_addr.size() == 0) begin
                chk("unexpected_write", {16'b0, im_addr}, 32'hFFFF_FFFF);
            end else begin
                chk("write_addr", {16'b0, im_addr}, {16'b0, exp_addr.pop_front()});
                chk("write_data", im_wdata, exp_data.pop_front());
            end
        end
    end

    // Stream-level model: header count, packed words, XOR of everything before the check byte.
    task automatic model();
        int          cnt;
        logic [7:0]  cs;
        logic [31:0] w;
        cnt = {stream[0], stream[1]};
        exp_words = '0;
        if (cnt > MAXW) begin
            exp_err = 1'b1;
        end else begin
            cs = stream[0] ^ stream[1];
            for (int i = 0; i < cnt; i++) begin
                w = {stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]};
                cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
                exp_addr.push_back(BASE + 16'(i));
                exp_data.push_back(w);
            end
            exp_words = 16'(cnt);
            exp_err = (stream[2+4*cnt] != cs);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present a byte after a gap; returns at the negedge following the accepting edge.
    task automatic send(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_data = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_load(input int maxgap);
        model();
        act_addr.delete();
        act_data.delete();
        pulse_start();
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        chk("err_after_start", {31'b0, err}, 32'd0);
        foreach (stream[i]) send(stream[i], $urandom_range(0, maxgap));
        // Outcome must be visible in the first cycle after the final byte.
        chk("err_final", {31'b0, err}, {31'b0, exp_err});
        chk("core_rst_final", {31'b0, core_rst_f}, {31'b0, !exp_err});
        chk("busy_final", {31'b0, busy}, 32'd0);
        chk("in_ready_final", {31'b0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        chk("words_loaded", {16'b0, words_loaded}, {16'b0, exp_words});
        chk("writes_pending", exp_addr.size(), 32'd0);
    endtask

    task automatic set_good(input logic [7:0] ck);
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, ck};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_im_we", {31'b0, im_we}, 32'd0);
        chk("rst_core", {31'b0, core_rst_f}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_addr", {16'b0, im_addr}, 32'd0);
        chk("rst_wdata", im_wdata, 32'd0);
        chk("rst_words", {16'b0, words_loaded}, 32'd0);
        rst_f = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", {31'b0, in_ready}, 32'd0);

        // Good load, no gaps
        set_good(8'h02);
        run_load(0);
        chk("good_exp_err", {31'b0, exp_err}, 32'd0);
        chk("good_w0", act_data.size() > 0 ? act_data[0] : 32'hDEAD, 32'h12345678);
        chk("good_w1", act_data.size() > 1 ? act_data[1] : 32'hDEAD, 32'h9ABCDEF0);
        chk("good_a1", act_addr.size() > 1 ? {16'b0, act_addr[1]} : 32'hDEAD, 32'h0001);
        chk("good_words", {16'b0, words_loaded}, 32'd2);
        chk("good_core", {31'b0, core_rst_f}, 32'd1);

        // Bad checksum
        set_good(8'h03);
        run_load(0);
        chk("bad_err", {31'b0, err}, 32'd1);
        chk("bad_core", {31'b0, core_rst_f}, 32'd0);
        chk("bad_nwrites", act_data.size(), 32'd2);
        pulse_start();
        chk("restart_clears_err", {31'b0, err}, 32'd0);
        chk("restart_busy", {31'b0, busy}, 32'd1);
        // Finish this load as an empty one
        stream = '{8'h00, 8'h00, 8'h00};
        model();
        foreach (stream[i]) send(stream[i], 0);

        // Empty load
        stream = '{8'h00, 8'h00, 8'h00};
        run_load(1);
        chk("empty_core", {31'b0, core_rst_f}, 32'd1);
        chk("empty_words", {16'b0, words_loaded}, 32'd0);
        chk("empty_nwrites", act_data.size(), 32'd0);

        // Oversize count: 1025
        stream = '{8'h04, 8'h01};
        run_load(0);
        chk("over_err", {31'b0, err}, 32'd1);
        chk("over_in_ready", {31'b0, in_ready}, 32'd0);
        chk("over_nwrites", act_data.size(), 32'd0);

        // Limit count 1024 is legal: header accepted, loader waits in DATA
        pulse_start();
        send(8'h04, 0);
        send(8'h00, 0);
        chk("max_busy", {31'b0, busy}, 32'd1);
        chk("max_in_ready", {31'b0, in_ready}, 32'd1);

        // Reset mid-load after two data bytes
        send(8'h12, 0);
        send(8'h34, 0);
        #2 rst_f = 1'b0;
        #1;
        chk("arst_im_we", {31'b0, im_we}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_core", {31'b0, core_rst_f}, 32'd0);
        chk("arst_words", {16'b0, words_loaded}, 32'd0);
        @(negedge clk);
        rst_f = 1'b1;
        @(negedge clk);

        // Good load with random gaps after reset
        for (int r = 0; r < 3; r++) begin
            set_good(8'h02);
            run_load(3);
            chk("gap_w1", act_data.size() > 1 ? act_data[1] : 32'hDEAD, 32'h9ABCDEF0);
        end

        // Start in RUN drops core_rst_f and re-enters the header phase
        pulse_start();
        chk("run_restart_core", {31'b0, core_rst_f}, 32'd0);
        chk("run_restart_busy", {31'b0, busy}, 32'd1);
        chk("run_restart_ready", {31'b0, in_ready}, 32'd1);
        // Start while loading is ignored
        pulse_start();
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'hAA, 0);
        send(8'hBB, 0);
        send(8'hCC, 0);
        exp_addr.push_back(BASE);
        exp_data.push_back(32'hAABBCCDD);
        send(8'hDD, 0);
        send(8'h01 ^ 8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD, 0);
        chk("one_word_core", {31'b0, core_rst_f}, 32'd1);
        chk("one_word_words", {16'b0, words_loaded}, 32'd1);
        chk("one_word_pending", exp_addr.size(), 32'd0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
